// File: rtl/fft_ctrl.sv
// In-place radix-2 FFT address sequencer: one butterfly per cycle, LAT-cycle
// write-back pipeline, and a per-stage drain window that keeps reads behind writes.
module fft_ctrl #(
    parameter int unsigned LOG2N = 4,
    parameter int unsigned LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [LOG2N-1:0] stage
);

    localparam int unsigned      KW         = LOG2N - 1;
    localparam logic [KW-1:0]    K_LAST     = '1;
    localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] ONE        = LOG2N'(1);
    localparam logic [2:0]       DRAIN_LAST = 3'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic [2:0]       drain_q, drain_d;

    logic [LOG2N-1:0] k_ext, span, mask, pos, addr_a, addr_b, tw_shift;
    logic [KW-1:0]    pos_k, tw_val;

    logic             rd_pipe_q [LAT];
    logic [LOG2N-1:0] a_pipe_q  [LAT];
    logic [LOG2N-1:0] b_pipe_q  [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        stage_d = stage_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    k_d     = '0;
                    stage_d = '0;
                end
            end
            RUN: begin
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    k_d = '0;
                    if (stage_q == LAST_STAGE) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + ONE;
                    end
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                k_d     = '0;
                stage_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // grp*2*span + pos equals (k with its low s bits cleared) shifted left once, plus pos.
    always_comb begin
        k_ext    = {1'b0, k_q};
        span     = ONE << stage_q;
        mask     = span - ONE;
        pos      = k_ext & mask;
        addr_a   = ((k_ext & ~mask) << 1) | pos;
        addr_b   = addr_a | span;
        tw_shift = LAST_STAGE - stage_q;
        pos_k    = k_q & mask[KW-1:0];
        tw_val   = pos_k << tw_shift;
    end

    always_comb begin
        busy      = (state_q == RUN) || (state_q == DRAIN);
        done      = (state_q == FINISH);
        rd_en     = (state_q == RUN);
        rd_addr_a = rd_en ? addr_a : '0;
        rd_addr_b = rd_en ? addr_b : '0;
        tw_addr   = rd_en ? tw_val : '0;
        stage     = stage_q;
        wr_en     = rd_pipe_q[LAT-1];
        wr_addr_a = a_pipe_q[LAT-1];
        wr_addr_b = b_pipe_q[LAT-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                rd_pipe_q[i] <= 1'b0;
                a_pipe_q[i]  <= '0;
                b_pipe_q[i]  <= '0;
            end
        end else begin
            rd_pipe_q[0] <= rd_en;
            a_pipe_q[0]  <= rd_addr_a;
            b_pipe_q[0]  <= rd_addr_b;
            for (int unsigned i = 1; i < LAT; i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
                a_pipe_q[i]  <= a_pipe_q[i-1];
                b_pipe_q[i]  <= b_pipe_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl: LOG2N=4 with LAT=1 and LAT=3 instances sharing clk/rst/start.
module tb_fft_ctrl;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic start = 1'b0;

    logic       busy1, done1, rd1, wr1;
    logic [3:0] ra1, rb1, wa1, wb1, st1;
    logic [2:0] tw1;
    logic       busy3, done3, rd3, wr3;
    logic [3:0] ra3, rb3, wa3, wb3, st3;
    logic [2:0] tw3;

    fft_ctrl #(.LOG2N(4), .LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy1), .done(done1), .rd_en(rd1),
        .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_addr(tw1),
        .wr_en(wr1), .wr_addr_a(wa1), .wr_addr_b(wb1), .stage(st1)
    );

    fft_ctrl #(.LOG2N(4), .LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy3), .done(done3), .rd_en(rd3),
        .rd_addr_a(ra3), .rd_addr_b(rb3), .tw_addr(tw3),
        .wr_en(wr3), .wr_addr_a(wa3), .wr_addr_b(wb3), .stage(st3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        o_busy, o_done, o_rd, o_wr;
    logic [31:0] o_ra, o_rb, o_tw, o_wa, o_wb, o_st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int L);
        if (L == 3) begin
            o_busy = busy3; o_done = done3; o_rd = rd3; o_wr = wr3;
            o_ra = 32'(ra3); o_rb = 32'(rb3); o_tw = 32'(tw3);
            o_wa = 32'(wa3); o_wb = 32'(wb3); o_st = 32'(st3);
        end else begin
            o_busy = busy1; o_done = done1; o_rd = rd1; o_wr = wr1;
            o_ra = 32'(ra1); o_rb = 32'(rb1); o_tw = 32'(tw1);
            o_wa = 32'(wa1); o_wb = 32'(wb1); o_st = 32'(st1);
        end
    endtask

    function automatic bit in_rd(input int c, input int P);
        if (c < 1 || c > 4 * P) return 1'b0;
        return ((c - 1) % P) < 8;
    endfunction

    function automatic int exp_a(input int s, input int k);
        int span = 1 << s;
        return (k / span) * 2 * span + (k % span);
    endfunction

    function automatic int exp_tw(input int s, input int k);
        int span = 1 << s;
        return (k % span) << (3 - s);
    endfunction

    task automatic check_zero(input string tag, input int L);
        sample(L);
        chk({tag, " busy"},  32'(o_busy), 0);
        chk({tag, " done"},  32'(o_done), 0);
        chk({tag, " rd_en"}, 32'(o_rd), 0);
        chk({tag, " wr_en"}, 32'(o_wr), 0);
        chk({tag, " rd_a"},  o_ra, 0);
        chk({tag, " rd_b"},  o_rb, 0);
        chk({tag, " tw"},    o_tw, 0);
        chk({tag, " wr_a"},  o_wa, 0);
        chk({tag, " wr_b"},  o_wb, 0);
        chk({tag, " stage"}, o_st, 0);
    endtask

    // Caller raises start before the edge that this task treats as cycle 0.
    task automatic run_and_check(input int L, input int pulse_c, input bit hold_end);
        int P      = 8 + L;
        int total  = 4 * P;
        int last_c = total + 2;
        int rdcnt [16];
        int wrcnt [16];
        bit er, ew;
        int s, k;
        foreach (rdcnt[i]) begin rdcnt[i] = 0; wrcnt[i] = 0; end
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            start = (c == pulse_c) || (hold_end && c >= total);
            sample(L);
            er = in_rd(c, P);
            ew = in_rd(c - L, P);
            chk($sformatf("L%0d rd_en c%0d", L, c), 32'(o_rd), 32'(er));
            chk($sformatf("L%0d wr_en c%0d", L, c), 32'(o_wr), 32'(ew));
            chk($sformatf("L%0d busy c%0d", L, c), 32'(o_busy), 32'(c >= 1 && c <= total));
            chk($sformatf("L%0d done c%0d", L, c), 32'(o_done), 32'(c == total + 1));
            if (er) begin
                s = (c - 1) / P;
                k = (c - 1) % P;
                chk($sformatf("L%0d rd_a c%0d", L, c), o_ra, 32'(exp_a(s, k)));
                chk($sformatf("L%0d rd_b c%0d", L, c), o_rb, 32'(exp_a(s, k) + (1 << s)));
                chk($sformatf("L%0d tw c%0d", L, c), o_tw, 32'(exp_tw(s, k)));
                chk($sformatf("L%0d stage c%0d", L, c), o_st, 32'(s));
                if (o_ra < 16) rdcnt[o_ra]++;
                if (o_rb < 16) rdcnt[o_rb]++;
                if (k == 7) begin
                    for (int a = 0; a < 16; a++) begin
                        chk($sformatf("L%0d rd cover s%0d a%0d", L, s, a), 32'(rdcnt[a]), 1);
                        rdcnt[a] = 0;
                    end
                end
            end
            if (ew) begin
                s = (c - L - 1) / P;
                k = (c - L - 1) % P;
                chk($sformatf("L%0d wr_a c%0d", L, c), o_wa, 32'(exp_a(s, k)));
                chk($sformatf("L%0d wr_b c%0d", L, c), o_wb, 32'(exp_a(s, k) + (1 << s)));
                if (o_wa < 16) wrcnt[o_wa]++;
                if (o_wb < 16) wrcnt[o_wb]++;
                if (k == 7) begin
                    for (int a = 0; a < 16; a++) begin
                        chk($sformatf("L%0d wr cover s%0d a%0d", L, s, a), 32'(wrcnt[a]), 1);
                        wrcnt[a] = 0;
                    end
                end
            end
            if (er && ew) begin
                chk($sformatf("L%0d rw disjoint c%0d", L, c),
                    32'(o_ra != o_wa && o_ra != o_wb && o_rb != o_wa && o_rb != o_wb), 1);
            end
        end
    endtask

    task automatic gap();
        repeat (12) @(negedge clk);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check_zero("por L1", 1);
        check_zero("por L3", 3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single start pulse with full timing, address and coverage checks.
        @(negedge clk);
        start = 1'b1;
        run_and_check(1, 0, 1'b0);

        // Extra start pulse mid-run is ignored.
        gap();
        start = 1'b1;
        run_and_check(1, 5, 1'b0);

        // start held through FINISH relaunches straight from IDLE.
        gap();
        start = 1'b1;
        run_and_check(1, 0, 1'b1);
        run_and_check(1, 0, 1'b0);

        // Asynchronous reset in cycle 12 aborts the run.
        gap();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        sample(1);
        chk("busy before rst", 32'(o_busy), 1);
        #2 rst = 1'b1;
        #1;
        check_zero("midrun L1", 1);
        check_zero("midrun L3", 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sample(1);
            chk($sformatf("rst hold wr_en %0d", i), 32'(o_wr), 0);
            chk($sformatf("rst hold done %0d", i), 32'(o_done), 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sample(1);
            chk($sformatf("post rst wr_en %0d", i), 32'(o_wr), 0);
            chk($sformatf("post rst done %0d", i), 32'(o_done), 0);
            chk($sformatf("post rst busy %0d", i), 32'(o_busy), 0);
        end
        start = 1'b1;
        run_and_check(1, 0, 1'b0);

        // Longer memory latency: 3-cycle drain, 44 busy cycles.
        gap();
        start = 1'b1;
        run_and_check(3, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
